// File: rtl/mips_seq_alu.sv
// Registered MIPS ALU with iterative unsigned multiply and divide.
//
// The single-cycle ops use the classic ALUctl encodings and finish one edge after the start is
// accepted. MULU and DIVU run WIDTH iterations with busy high, then write {HI,LO} and ALUOut.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start               request, sampled only while busy is low
//   ALUctl, A, B        operation and operands, latched when a start is accepted
//   ALUOut, Zero        registered result and (ALUOut == 0)
//   HI, LO              mul upper/lower product half, div remainder/quotient
//   busy, done          multi-cycle op in progress / one-cycle result-valid pulse
//   div0                most recent accepted DIVU had B == 0
module mips_seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e             state_q, state_d;
  logic               is_div_q;
  logic [WIDTH-1:0]   opnd_q;    // multiplicand (MULU) or divisor (DIVU)
  logic [WIDTH-1:0]   hi_acc_q;  // partial product high half / partial remainder
  logic [WIDTH-1:0]   lo_acc_q;  // multiplier being shifted out / quotient being shifted in
  logic [CNT_W-1:0]   cnt_q;

  logic               accept, is_mul_op, is_div_op, is_long_op, last_step;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   step_hi, step_lo;

  assign accept     = start && (state_q != StCalc);
  assign is_mul_op  = (ALUctl == 4'b1000);
  assign is_div_op  = (ALUctl == 4'b1001);
  assign is_long_op = is_mul_op || is_div_op;
  assign last_step  = (cnt_q == CNT_W'(1));
  assign busy       = (state_q == StCalc);
  assign done       = (state_q == StDone);

  always_comb begin
    alu_res = '0;
    case (ALUctl)
      4'b0000: alu_res = A & B;
      4'b0001: alu_res = A | B;
      4'b0010: alu_res = A + B;
      4'b0110: alu_res = A - B;
      4'b0111: alu_res = ($signed(A) < $signed(B)) ? WIDTH'(1) : '0;
      4'b1100: alu_res = ~(A | B);
      default: alu_res = '0;
    endcase
  end

  // Shift-add multiply: add the multiplicand when the multiplier LSB is set, then shift the
  // whole {carry, hi, lo} right by one.
  assign mul_sum = {1'b0, hi_acc_q} + (lo_acc_q[0] ? {1'b0, opnd_q} : '0);

  // Restoring divide: shift the next dividend bit into the remainder and subtract if it fits.
  // With a zero divisor every step "fits", which leaves quotient = all ones and remainder = A.
  assign div_shift = {hi_acc_q, lo_acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

  always_comb begin
    step_hi = '0;
    step_lo = '0;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {lo_acc_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) state_d = is_long_op ? StCalc : StDone;
        else       state_d = StIdle;
      end
      StCalc:  if (last_step) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      hi_acc_q <= '0;
      lo_acc_q <= '0;
      cnt_q    <= '0;
      ALUOut   <= '0;
      Zero     <= 1'b1;
      HI       <= '0;
      LO       <= '0;
      div0     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (is_long_op) begin
          is_div_q <= is_div_op;
          opnd_q   <= is_div_op ? B : A;
          lo_acc_q <= is_div_op ? A : B;
          hi_acc_q <= '0;
          cnt_q    <= CNT_W'(WIDTH);
          if (is_div_op) div0 <= (B == '0);
        end else begin
          ALUOut <= alu_res;
          Zero   <= (alu_res == '0);
        end
      end else if (state_q == StCalc) begin
        hi_acc_q <= step_hi;
        lo_acc_q <= step_lo;
        cnt_q    <= cnt_q - CNT_W'(1);
        if (last_step) begin
          HI     <= step_hi;
          LO     <= step_lo;
          ALUOut <= step_lo;
          Zero   <= (step_lo == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_seq_alu.sv
// Self-checking bench for mips_seq_alu: directed table, multi-cycle corner sequences and
// randomized ops compared against a plain-arithmetic reference model.
module tb_mips_seq_alu;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALUctl;
  logic [31:0] A, B;
  logic [31:0] ALUOut, HI, LO;
  logic        Zero, busy, done, div0;

  logic        start8;
  logic [3:0]  ctl8;
  logic [7:0]  a8, b8;
  logic [7:0]  out8, hi8, lo8;
  logic        zero8, busy8, done8, div08;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: HI/LO/div0 persist across single-cycle ops.
  logic [31:0] m_alu, m_hi, m_lo;
  logic        m_div0;

  always #5 clock = ~clock;

  mips_seq_alu #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .ALUctl(ALUctl), .A(A), .B(B),
    .ALUOut(ALUOut), .Zero(Zero), .HI(HI), .LO(LO), .busy(busy), .done(done), .div0(div0)
  );

  mips_seq_alu #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .ALUctl(ctl8), .A(a8), .B(b8),
    .ALUOut(out8), .Zero(zero8), .HI(hi8), .LO(lo8), .busy(busy8), .done(done8), .div0(div08)
  );

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_apply(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    case (c)
      4'b0000: m_alu = a & b;
      4'b0001: m_alu = a | b;
      4'b0010: m_alu = a + b;
      4'b0110: m_alu = a - b;
      4'b0111: m_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: m_alu = ~(a | b);
      4'b1000: begin
        prod  = 64'(a) * 64'(b);
        m_hi  = prod[63:32];
        m_lo  = prod[31:0];
        m_alu = m_lo;
      end
      4'b1001: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a; m_div0 = 1'b1;
        end else begin
          m_lo = a / b; m_hi = a % b; m_div0 = 1'b0;
        end
        m_alu = m_lo;
      end
      default: m_alu = 32'd0;
    endcase
  endtask

  // Issue one MULU/DIVU, scrambling inputs while busy; returns busy-cycle count and done flag.
  task automatic do_long(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cyc, output bit got_done);
    start = 1'b1; ALUctl = c; A = a; B = b;
    tick();
    start = 1'b0;
    busy_cyc = 0;
    got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      start = 1'($urandom); A = $urandom; B = $urandom; ALUctl = 4'($urandom);
      tick();
    end
    start = 1'b0;
    if (!got_done) check("long_op_timeout", 64'(got_done), 64'd1);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_aluout"}, 64'(ALUOut), 64'(m_alu));
    check({tag, "_zero"},   64'(Zero),   64'(m_alu == 0));
    check({tag, "_hi"},     64'(HI),     64'(m_hi));
    check({tag, "_lo"},     64'(LO),     64'(m_lo));
    check({tag, "_div0"},   64'(div0),   64'(m_div0));
  endtask

  initial begin
    vec_t vecs[9];
    logic [3:0] codes[10];
    int bc;
    bit gd;

    vecs[0] = '{4'b0000, 32'd12, 32'd10, 32'd8};
    vecs[1] = '{4'b0001, 32'd12, 32'd10, 32'd14};
    vecs[2] = '{4'b0010, 32'd12, 32'd10, 32'd22};
    vecs[3] = '{4'b0110, 32'd12, 32'd10, 32'd2};
    vecs[4] = '{4'b0111, 32'd12, 32'd10, 32'd0};
    vecs[5] = '{4'b1100, 32'd12, 32'd10, 32'hFFFF_FFF1};
    vecs[6] = '{4'b0110, 32'd10, 32'd12, 32'hFFFF_FFFE};
    vecs[7] = '{4'b0111, 32'd10, 32'd12, 32'd1};
    vecs[8] = '{4'b0110, 32'd5,  32'd5,  32'd0};
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
              4'b1000, 4'b1001, 4'b0011, 4'b1111};

    reset = 1'b1; start = 1'b0; ALUctl = '0; A = '0; B = '0;
    start8 = 1'b0; ctl8 = '0; a8 = '0; b8 = '0;
    m_alu = '0; m_hi = '0; m_lo = '0; m_div0 = 1'b0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check_outputs("rst");
    reset = 1'b0;
    tick();

    // Back-to-back single-cycle ops: done every cycle, busy never.
    for (int i = 0; i < 9; i++) begin
      start = 1'b1; ALUctl = vecs[i].ctl; A = vecs[i].a; B = vecs[i].b;
      tick();
      check($sformatf("vec%0d_aluout", i), 64'(ALUOut), 64'(vecs[i].exp_out));
      check($sformatf("vec%0d_zero", i), 64'(Zero), 64'(vecs[i].exp_out == 0));
      check($sformatf("vec%0d_done", i), 64'(done), 64'd1);
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
      check($sformatf("vec%0d_hi", i), 64'(HI), 64'd0);
    end
    start = 1'b0;
    tick();
    check("done_to_idle", 64'(done), 64'd0);
    check("hold_aluout", 64'(ALUOut), 64'd0);
    m_alu = 32'd0;

    do_long(4'b1000, 32'hFFFF_FFFF, 32'd2, bc, gd);
    check("mulu_busy_cycles", 64'(bc), 64'd32);
    check("mulu_hi", 64'(HI), 64'd1);
    check("mulu_lo", 64'(LO), 64'hFFFF_FFFE);
    check("mulu_aluout", 64'(ALUOut), 64'hFFFF_FFFE);

    do_long(4'b1001, 32'd100, 32'd7, bc, gd);
    check("divu_busy_cycles", 64'(bc), 64'd32);
    check("divu_lo", 64'(LO), 64'd14);
    check("divu_hi", 64'(HI), 64'd2);
    check("divu_div0", 64'(div0), 64'd0);

    do_long(4'b1001, 32'd9, 32'd0, bc, gd);
    check("div0_busy_cycles", 64'(bc), 64'd32);
    check("div0_lo", 64'(LO), 64'hFFFF_FFFF);
    check("div0_hi", 64'(HI), 64'd9);
    check("div0_aluout", 64'(ALUOut), 64'hFFFF_FFFF);
    check("div0_flag", 64'(div0), 64'd1);
    m_alu = 32'hFFFF_FFFF; m_hi = 32'd9; m_lo = 32'hFFFF_FFFF; m_div0 = 1'b1;

    // Single-cycle op leaves HI/LO/div0 alone.
    start = 1'b1; ALUctl = 4'b0010; A = 32'd1; B = 32'd1;
    tick();
    start = 1'b0;
    model_apply(4'b0010, 32'd1, 32'd1);
    check_outputs("add_keeps_hilo");

    // Asynchronous reset in the middle of a MULU.
    start = 1'b1; ALUctl = 4'b1000; A = 32'd123; B = 32'd456;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    #1;
    m_alu = '0; m_hi = '0; m_lo = '0; m_div0 = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check_outputs("midrst");
    tick();
    reset = 1'b0;
    tick();
    start = 1'b1; ALUctl = 4'b0010; A = 32'd3; B = 32'd4;
    tick();
    start = 1'b0;
    check("post_rst_add", 64'(ALUOut), 64'd7);
    check("post_rst_done", 64'(done), 64'd1);
    model_apply(4'b0010, 32'd3, 32'd4);

    // Randomized ops against the reference model.
    for (int n = 0; n < 24; n++) begin
      logic [3:0]  c;
      logic [31:0] a, b;
      c = codes[$urandom_range(0, 9)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = a;
      if (c == 4'b1000 || c == 4'b1001) begin
        do_long(c, a, b, bc, gd);
        check($sformatf("rnd%0d_busy_cycles", n), 64'(bc), 64'd32);
      end else begin
        start = 1'b1; ALUctl = c; A = a; B = b;
        tick();
        start = 1'b0;
        check($sformatf("rnd%0d_done", n), 64'(done), 64'd1);
      end
      model_apply(c, a, b);
      check_outputs($sformatf("rnd%0d", n));
    end

    // Narrow instance: 200 * 3 = 600 = 0x0258.
    start8 = 1'b1; ctl8 = 4'b1000; a8 = 8'd200; b8 = 8'd3;
    tick();
    start8 = 1'b0;
    bc = 0;
    gd = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done8) begin
        gd = 1'b1;
        break;
      end
      if (busy8) bc++;
      tick();
    end
    check("w8_done_seen", 64'(gd), 64'd1);
    check("w8_busy_cycles", 64'(bc), 64'd8);
    check("w8_hi", 64'(hi8), 64'h02);
    check("w8_lo", 64'(lo8), 64'h58);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
